rvsteel_gpio_irq: RTL and testbench

//   Memory-mapped GPIO with up to 32 pins, per-pin direction, output set/clear, and edge-triggered interrupts.
//   - Inputs pass a 2-flop synchronizer; a debounce filter is optional.
//   - Rising/falling edges latch into a W1C pending register; irq is the OR of pending bits.
//   - Sits on the system IO bus as a slave, same bus handshake as the other peripherals.

---
 rtl/rvsteel_gpio_irq.sv | 244 ++++++++++++++++++++++++
 tb/tb_rvsteel_gpio_irq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : rvsteel_gpio_irq
// Purpose  : Memory-mapped GPIO block with up to 32 pins. Each pin has its own
//            direction control. The output register can be written directly or
//            through set/clear aliases. Rising and falling edges are latched
//            into a write-one-to-clear pending register, and irq is the OR of
//            the pending bits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   GPIO_WIDTH       number of pins (1..32)
//   DEBOUNCE_CYCLES  cycles an input must stay stable before the filtered
//                    value follows it (>= 1; only used with the debounce build)
// Ports:
//   clock, reset     system clock; synchronous active-high reset
//   rw_address       byte address, [4:2] selects the register
//   read_data        registered read data
//   read_request     read strobe     -> read_response one cycle later
//   write_data       write data
//   write_strobe     byte enables; only 4'b1111 performs a write
//   write_request    write strobe    -> write_response one cycle later
//   gpio_input       asynchronous pin inputs
//   gpio_oe          per-pin output enable (1 = drive)
//   gpio_output      per-pin output value
//   irq              level interrupt, |PENDING
// Configuration macro:
//   RVSTEEL_GPIO_DEBOUNCE_EN  adds a per-pin debounce filter after the
//                             synchronizer
// Register map (word offset):
//   0 IN (RO)  1 OE  2 OUT  3 CLR (WO)  4 SET (WO)  5 RISE_EN  6 FALL_EN
//   7 PENDING (R/W1C)
// ============================================================================
module rvsteel_gpio_irq #(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            rw_address,
  output logic [31:0]           read_data,
  input  logic                  read_request,
  output logic                  read_response,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_strobe,
  input  logic                  write_request,
  output logic                  write_response,
  input  logic [GPIO_WIDTH-1:0] gpio_input,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic [GPIO_WIDTH-1:0] gpio_output,
  output logic                  irq
);

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OE      = 3'd1;
  localparam logic [2:0] REG_OUT     = 3'd2;
  localparam logic [2:0] REG_CLR     = 3'd3;
  localparam logic [2:0] REG_SET     = 3'd4;
  localparam logic [2:0] REG_RISE_EN = 3'd5;
  localparam logic [2:0] REG_FALL_EN = 3'd6;
  localparam logic [2:0] REG_PENDING = 3'd7;

  // Elaboration-time parameter sanity checks.
  if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_width
    $error("rvsteel_gpio_irq: GPIO_WIDTH must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("rvsteel_gpio_irq: DEBOUNCE_CYCLES must be >= 1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [GPIO_WIDTH-1:0] oe_q, oe_d;
  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] pending_q, pending_d;
  logic [1:0]            arm_cnt_q, arm_cnt_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  read_response_q, write_response_q;

  logic [GPIO_WIDTH-1:0] filt;
  logic [GPIO_WIDTH-1:0] wd;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic [GPIO_WIDTH-1:0] rise, fall;
  logic [GPIO_WIDTH-1:0] rd_sel;
  logic [31:0]           rd_word;
  logic                  armed;
  logic                  wr_ok, rd_ok;

  // Bits of write_data above GPIO_WIDTH are intentionally ignored.
  logic unused_write_bits;
  assign unused_write_bits = ^write_data;

  assign wd    = write_data[GPIO_WIDTH-1:0];
  assign wr_ok = write_request && (rw_address[1:0] == 2'b00) && (write_strobe == 4'b1111);
  assign rd_ok = read_request && (rw_address[1:0] == 2'b00);

  // --------------------------------------------------------------------------
  // Optional debounce filter
  // --------------------------------------------------------------------------
`ifdef RVSTEEL_GPIO_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [GPIO_WIDTH-1:0] filt_q, filt_d;
  logic [CNT_W-1:0]      cnt_q [GPIO_WIDTH];
  logic [CNT_W-1:0]      cnt_d [GPIO_WIDTH];

  // Each counter counts consecutive cycles where the synchronized input
  // disagrees with the filtered value; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      logic [CNT_W-1:0] cnt_next;
      cnt_next = cnt_q[i] + 1'b1;
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_next == CNT_MAX) begin
          filt_d[i] = ~filt_q[i];
        end else begin
          cnt_d[i] = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  // --------------------------------------------------------------------------
  // Edge detection and arming
  // --------------------------------------------------------------------------
  // Edge detection stays off for three cycles after reset so that prev can
  // catch up with pins that were already high, avoiding a false rising edge.
  assign armed     = (arm_cnt_q == 2'd3);
  assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;

  assign rise = armed ? (filt & ~prev_q & rise_en_q) : '0;
  assign fall = armed ? (~filt & prev_q & fall_en_q) : '0;

  // --------------------------------------------------------------------------
  // Register writes
  // --------------------------------------------------------------------------
  always_comb begin
    oe_d      = oe_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_mask  = '0;
    if (wr_ok) begin
      case (rw_address[4:2])
        REG_OE:      oe_d      = wd;
        REG_OUT:     out_d     = wd;
        REG_CLR:     out_d     = out_q & ~wd;
        REG_SET:     out_d     = out_q | wd;
        REG_RISE_EN: rise_en_d = wd;
        REG_FALL_EN: fall_en_d = wd;
        REG_PENDING: w1c_mask  = wd;
        default:     ;
      endcase
    end
    // New edges are OR'd after the clear so a same-cycle edge survives a W1C.
    pending_d = (pending_q & ~w1c_mask) | rise | fall;
  end

  // --------------------------------------------------------------------------
  // Register reads
  // --------------------------------------------------------------------------
  always_comb begin
    case (rw_address[4:2])
      REG_IN:      rd_sel = filt;
      REG_OE:      rd_sel = oe_q;
      REG_OUT:     rd_sel = out_q;
      REG_RISE_EN: rd_sel = rise_en_q;
      REG_FALL_EN: rd_sel = fall_en_q;
      REG_PENDING: rd_sel = pending_q;
      default:     rd_sel = '0;
    endcase
    rd_word                 = '0;
    rd_word[GPIO_WIDTH-1:0] = rd_sel;
    read_data_d             = rd_ok ? rd_word : read_data_q;
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      prev_q           <= '0;
      oe_q             <= '0;
      out_q            <= '0;
      rise_en_q        <= '0;
      fall_en_q        <= '0;
      pending_q        <= '0;
      arm_cnt_q        <= '0;
      read_data_q      <= '0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
    end else begin
      sync1_q          <= gpio_input;
      sync2_q          <= sync1_q;
      prev_q           <= filt;
      oe_q             <= oe_d;
      out_q            <= out_d;
      rise_en_q        <= rise_en_d;
      fall_en_q        <= fall_en_d;
      pending_q        <= pending_d;
      arm_cnt_q        <= arm_cnt_d;
      read_data_q      <= read_data_d;
      read_response_q  <= read_request;
      write_response_q <= write_request;
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_response_q;
  assign write_response = write_response_q;
  assign gpio_oe        = oe_q;
  assign gpio_output    = out_q;
  assign irq            = |pending_q;

endmodule
`default_nettype wire

// File: tb/tb_rvsteel_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvsteel_gpio_irq
// Purpose  : Self-checking bench for rvsteel_gpio_irq. Bus reads push their
//            expected data into a scoreboard queue; a monitor pops and compares
//            whenever read_response is seen, and also checks the one-cycle
//            response timing of every request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvsteel_gpio_irq;

  localparam int W  = 8;
  localparam int DB = 16;
`ifdef RVSTEEL_GPIO_DEBOUNCE_EN
  localparam int EXTRA = DB;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [4:0] A_IN   = 5'h00;
  localparam logic [4:0] A_OE   = 5'h04;
  localparam logic [4:0] A_OUT  = 5'h08;
  localparam logic [4:0] A_CLR  = 5'h0C;
  localparam logic [4:0] A_SET  = 5'h10;
  localparam logic [4:0] A_RISE = 5'h14;
  localparam logic [4:0] A_FALL = 5'h18;
  localparam logic [4:0] A_PEND = 5'h1C;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    rw_address;
  logic [31:0]   read_data;
  logic          read_request;
  logic          read_response;
  logic [31:0]   write_data;
  logic [3:0]    write_strobe;
  logic          write_request;
  logic          write_response;
  logic [W-1:0]  gpio_input;
  logic [W-1:0]  gpio_oe;
  logic [W-1:0]  gpio_output;
  logic          irq;

  rvsteel_gpio_irq #(
    .GPIO_WIDTH      (W),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_request  (write_request),
    .write_response (write_response),
    .gpio_input     (gpio_input),
    .gpio_oe        (gpio_oe),
    .gpio_output    (gpio_output),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        rd_q[$];
  logic [31:0] last_rd;

  function automatic void check(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endfunction

  // Monitor: responses must follow requests by one cycle; read data is
  // matched against the scoreboard in issue order.
  always @(posedge clock) begin
    logic rq, wq, rs;
    exp_t e;
    rq = read_request;
    wq = write_request;
    rs = reset;
    #1;
    if ((rq && !rs) || read_response)
      check("read_response", 32'(read_response), 32'(rq && !rs));
    if ((wq && !rs) || write_response)
      check("write_response", 32'(write_response), 32'(wq && !rs));
    if (read_response) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read_response", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        check(e.tag, read_data, e.data);
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s = 4'b1111);
    rw_address    = a;
    write_data    = d;
    write_strobe  = s;
    write_request = 1'b1;
    @(negedge clock);
    write_request = 1'b0;
  endtask

  // Misaligned reads leave read_data unchanged, so the expectation is the
  // last aligned read's value.
  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    rw_address   = a;
    read_request = 1'b1;
    if (a[1:0] == 2'b00) last_rd = exp;
    rd_q.push_back('{data: last_rd, tag: tag});
    @(negedge clock);
    read_request = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset         = 1'b1;
    rw_address    = '0;
    read_request  = 1'b0;
    write_data    = '0;
    write_strobe  = '0;
    write_request = 1'b0;
    gpio_input    = '0;
    last_rd       = '0;

    // ---- reset state ----
    wait_cycles(3);
    check("reset_gpio_oe", 32'(gpio_oe), 32'h0);
    check("reset_gpio_output", 32'(gpio_output), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_read_data", read_data, 32'h0);
    reset = 1'b0;
    wait_cycles(4);
    bus_read(A_IN,   32'h0, "rst_in");
    bus_read(A_OE,   32'h0, "rst_oe");
    bus_read(A_OUT,  32'h0, "rst_out");
    bus_read(A_RISE, 32'h0, "rst_rise_en");
    bus_read(A_FALL, 32'h0, "rst_fall_en");
    bus_read(A_PEND, 32'h0, "rst_pending");

    // ---- OE / SET / CLR ----
    bus_write(A_OE,  32'h1234_56FF);
    bus_write(A_SET, 32'h0000_0005);
    bus_write(A_CLR, 32'h0000_0001);
    check("t1_gpio_oe", 32'(gpio_oe), 32'hFF);
    check("t1_gpio_output", 32'(gpio_output), 32'h04);
    bus_read(A_OUT, 32'h04, "t1_out");
    bus_read(A_SET, 32'h0,  "t1_set_reads_zero");
    bus_read(A_CLR, 32'h0,  "t1_clr_reads_zero");
    bus_read(A_OE,  32'hFF, "t1_oe_upper_ignored");

    // ---- rejected writes / misaligned read ----
    bus_write(A_OE, 32'h0, 4'b0011);
    bus_write(5'h09, 32'h0);
    bus_write(5'h0A, 32'hFF);
    check("t4_gpio_oe", 32'(gpio_oe), 32'hFF);
    check("t4_gpio_output", 32'(gpio_output), 32'h04);
    bus_read(5'h09, 32'hDEAD_BEEF, "t4_misaligned_read_holds");
    bus_read(A_OUT, 32'h04, "t4_out_unchanged");

    // ---- rising edge on pin 0 ----
    bus_write(A_RISE, 32'h01);
    gpio_input[0] = 1'b1;
    wait_cycles(2 + EXTRA);
    check("t2_irq_before_latency", 32'(irq), 32'h0);
    wait_cycles(1);
    check("t2_irq_at_latency", 32'(irq), 32'h1);
    bus_read(A_PEND, 32'h01, "t2_pending");
    bus_read(A_IN,   32'h01, "t2_in");
    bus_write(A_PEND, 32'h01);
    check("t2_irq_after_w1c", 32'(irq), 32'h0);
    bus_read(A_PEND, 32'h00, "t2_pending_cleared");

    // ---- falling edge on pin 1 colliding with W1C ----
    gpio_input[1] = 1'b1;
    wait_cycles(6 + EXTRA);
    check("t3_no_rise_when_disabled", 32'(irq), 32'h0);
    bus_write(A_FALL, 32'h02);
    gpio_input[1] = 1'b0;
    wait_cycles(2 + EXTRA);
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, 32'h02, "t3_edge_beats_w1c");
    check("t3_irq", 32'(irq), 32'h1);
    bus_write(A_FALL, 32'h00);
    bus_read(A_PEND, 32'h02, "t3_disable_keeps_pending");
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, 32'h00, "t3_pending_cleared");

`ifdef RVSTEEL_GPIO_DEBOUNCE_EN
    // ---- debounce: short pulse rejected, long pulse accepted ----
    bus_write(A_RISE, 32'h04);
    gpio_input[2] = 1'b1;
    wait_cycles(10);
    gpio_input[2] = 1'b0;
    wait_cycles(30);
    bus_read(A_IN,   32'h01, "t6_short_pulse_in");
    bus_read(A_PEND, 32'h00, "t6_short_pulse_pending");
    gpio_input[2] = 1'b1;
    wait_cycles(18);
    bus_read(A_IN, 32'h05, "t6_long_pulse_in");
    wait_cycles(1);
    gpio_input[2] = 1'b0;
    wait_cycles(30);
    bus_read(A_PEND, 32'h04, "t6_long_pulse_pending");
    bus_read(A_IN,   32'h01, "t6_in_after_pulse");
    bus_write(A_PEND, 32'h04);
`endif

    // ---- pins high through reset give no spurious edge ----
    gpio_input = 8'hFF;
    reset      = 1'b1;
    wait_cycles(3);
    check("t5_reset_gpio_oe", 32'(gpio_oe), 32'h0);
    check("t5_reset_gpio_output", 32'(gpio_output), 32'h0);
    reset   = 1'b0;
    last_rd = '0;
    if (EXTRA > 0) wait_cycles(EXTRA + 4);
    bus_write(A_RISE, 32'hFF);
    wait_cycles(10);
    bus_read(A_PEND, 32'h00, "t5_no_spurious_pending");
    check("t5_irq", 32'(irq), 32'h0);
    bus_read(A_IN,   32'hFF, "t5_in");
    bus_read(A_RISE, 32'hFF, "t5_rise_en");

    // After arming, a genuine edge is still detected.
    gpio_input[3] = 1'b0;
    wait_cycles(4 + EXTRA);
    gpio_input[3] = 1'b1;
    wait_cycles(4 + EXTRA);
    bus_read(A_PEND, 32'h08, "t5_edge_after_arming");
    check("t5_irq_after_edge", 32'(irq), 32'h1);

    wait_cycles(3);
    check("scoreboard_drained", 32'(rd_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
